// File: rtl/rosc_ctrl_pkg.sv
// Shared types and widths for the two-channel ring-oscillator controller.
package rosc_ctrl_pkg;

  localparam int unsigned TRIM_W = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STARTUP,
    ST_READY,
    ST_SETTLE,
    ST_STOP
  } rosc_state_e;

endpackage : rosc_ctrl_pkg

// File: rtl/rosc_ctrl_if.sv
// Request/trim/status bundle between a clock consumer and rosc_ctrl.
interface rosc_ctrl_if;
  import rosc_ctrl_pkg::*;

  logic              req_16mhz;
  logic              req_2mhz;
  logic              trim_16mhz_wr;
  logic              trim_2mhz_wr;
  logic [TRIM_W-1:0] trim_16mhz_in;
  logic [TRIM_W-1:0] trim_2mhz_in;
  logic              en_16mhz;
  logic              en_2mhz;
  logic [TRIM_W-1:0] trim_16mhz;
  logic [TRIM_W-1:0] trim_2mhz;
  logic              rdy_16mhz;
  logic              rdy_2mhz;
  logic              busy;

  // Requester side.
  modport master (
    output req_16mhz, req_2mhz, trim_16mhz_wr, trim_2mhz_wr,
           trim_16mhz_in, trim_2mhz_in,
    input  en_16mhz, en_2mhz, trim_16mhz, trim_2mhz,
           rdy_16mhz, rdy_2mhz, busy
  );

  // Controller side.
  modport slave (
    input  req_16mhz, req_2mhz, trim_16mhz_wr, trim_2mhz_wr,
           trim_16mhz_in, trim_2mhz_in,
    output en_16mhz, en_2mhz, trim_16mhz, trim_2mhz,
           rdy_16mhz, rdy_2mhz, busy
  );

endinterface : rosc_ctrl_if

// File: rtl/rosc_chan.sv
// One oscillator channel: state machine, 8-bit saturating down-counter, trim register.
module rosc_chan
  import rosc_ctrl_pkg::*;
#(
  parameter int unsigned STARTUP_CYC = 64,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned OFF_CYC     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              trim_wr_i,
  input  logic [TRIM_W-1:0] trim_i,
  output logic              en_o,
  output logic              rdy_o,
  output logic [TRIM_W-1:0] trim_o,
  output logic              busy_o
);

  // Counter reload values: the state is left on the edge that sees zero,
  // so loading N-1 gives exactly N cycles in the timed state.
  localparam logic [CNT_W-1:0] SU_LOAD  = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LOAD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYC - 1);

  rosc_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic              en_q, en_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  // State, counter, trim and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      trim_q  <= '0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trim_q  <= trim_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, counter and trim update; outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trim_d  = trim_q;
    if (trim_wr_i) trim_d = trim_i;

    unique case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (req_i) begin
          state_d = ST_STARTUP;
          cnt_d   = SU_LOAD;
        end
      end
      ST_STARTUP: begin
        if (!req_i) begin
          state_d = ST_STOP;
          cnt_d   = OFF_LOAD;
        end else if (trim_wr_i) begin
          cnt_d = SU_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READY: begin
        cnt_d = '0;
        if (!req_i) begin
          state_d = ST_STOP;
          cnt_d   = OFF_LOAD;
        end else if (trim_wr_i) begin
          state_d = ST_SETTLE;
          cnt_d   = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!req_i) begin
          state_d = ST_STOP;
          cnt_d   = OFF_LOAD;
        end else if (trim_wr_i) begin
          cnt_d = ST_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        // The edge that completes the off time counts as reaching OFF, so a
        // pending request restarts there and en stays low exactly OFF_CYC cycles.
        if (cnt_q == '0) begin
          if (req_i) begin
            state_d = ST_STARTUP;
            cnt_d   = SU_LOAD;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    en_d   = (state_d == ST_STARTUP) || (state_d == ST_READY) || (state_d == ST_SETTLE);
    rdy_d  = (state_d == ST_READY);
    busy_d = (state_d == ST_STARTUP) || (state_d == ST_SETTLE) || (state_d == ST_STOP);
  end

  assign en_o   = en_q;
  assign rdy_o  = rdy_q;
  assign trim_o = trim_q;
  assign busy_o = busy_q;

endmodule : rosc_chan

// File: rtl/rosc_ctrl.sv
// Two independent oscillator channels (16 MHz, 2 MHz) plus a combined busy flag.
module rosc_ctrl
  import rosc_ctrl_pkg::*;
#(
  parameter int unsigned STARTUP_CYC = 64,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned OFF_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  rosc_ctrl_if.slave  bus
);

  logic busy16, busy2;

  rosc_chan #(
    .STARTUP_CYC (STARTUP_CYC),
    .SETTLE_CYC  (SETTLE_CYC),
    .OFF_CYC     (OFF_CYC)
  ) u_chan_16mhz (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.req_16mhz),
    .trim_wr_i (bus.trim_16mhz_wr),
    .trim_i    (bus.trim_16mhz_in),
    .en_o      (bus.en_16mhz),
    .rdy_o     (bus.rdy_16mhz),
    .trim_o    (bus.trim_16mhz),
    .busy_o    (busy16)
  );

  rosc_chan #(
    .STARTUP_CYC (STARTUP_CYC),
    .SETTLE_CYC  (SETTLE_CYC),
    .OFF_CYC     (OFF_CYC)
  ) u_chan_2mhz (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.req_2mhz),
    .trim_wr_i (bus.trim_2mhz_wr),
    .trim_i    (bus.trim_2mhz_in),
    .en_o      (bus.en_2mhz),
    .rdy_o     (bus.rdy_2mhz),
    .trim_o    (bus.trim_2mhz),
    .busy_o    (busy2)
  );

  assign bus.busy = busy16 | busy2;

endmodule : rosc_ctrl

// File: tb/tb_rosc_ctrl.sv
// Directed bench for rosc_ctrl with an expected-value queue.
module tb_rosc_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  rosc_ctrl_if bus ();

  rosc_ctrl #(
    .STARTUP_CYC (64),
    .SETTLE_CYC  (16),
    .OFF_CYC     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int unsigned ncmp  = 0;
  int unsigned nfail = 0;

  // Expected per-channel state, maintained by hand alongside the stimulus.
  logic       e_en16, e_rdy16, e_b16;
  logic [1:0] e_tr16;
  logic       e_en2, e_rdy2, e_b2;
  logic [1:0] e_tr2;

  function automatic logic [8:0] expv();
    return {e_en16, e_rdy16, e_tr16, e_en2, e_rdy2, e_tr2, (e_b16 | e_b2)};
  endfunction

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.v   = expv();
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    logic [8:0] obs;
    e   = sb.pop_front();
    obs = {bus.en_16mhz, bus.rdy_16mhz, bus.trim_16mhz,
           bus.en_2mhz, bus.rdy_2mhz, bus.trim_2mhz, bus.busy};
    ncmp++;
    assert (obs === e.v)
    else begin
      nfail++;
      $error("FAIL %s observed={en16,rdy16,tr16,en2,rdy2,tr2,busy}=%b expected=%b",
             e.tag, obs, e.v);
    end
  endtask

  // Compare without a clock edge.
  task automatic chk(input string tag);
    push(tag);
    pop_cmp();
  endtask

  // Expectation queued with the stimulus, checked 1 ns after the next edge.
  task automatic step(input string tag);
    push(tag);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic steps(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.req_16mhz     = 1'b0;
    bus.req_2mhz      = 1'b0;
    bus.trim_16mhz_wr = 1'b0;
    bus.trim_2mhz_wr  = 1'b0;
    bus.trim_16mhz_in = 2'b00;
    bus.trim_2mhz_in  = 2'b00;
    {e_en16, e_rdy16, e_b16, e_tr16} = '0;
    {e_en2,  e_rdy2,  e_b2,  e_tr2}  = '0;

    #3;
    chk("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle");

    // 16 MHz startup: en on the request edge, rdy 64 edges later.
    bus.req_16mhz = 1'b1;
    e_en16 = 1'b1; e_b16 = 1'b1;
    step("a_start");
    steps("a_startup", 63);
    e_rdy16 = 1'b1; e_b16 = 1'b0;
    step("a_ready");

    // 2 MHz startup, then trim write in READY -> 16-cycle settle.
    bus.req_2mhz = 1'b1;
    e_en2 = 1'b1; e_b2 = 1'b1;
    step("b_start");
    steps("b_startup", 63);
    e_rdy2 = 1'b1; e_b2 = 1'b0;
    step("b_ready");
    bus.trim_2mhz_wr = 1'b1; bus.trim_2mhz_in = 2'b11;
    e_tr2 = 2'b11; e_rdy2 = 1'b0; e_b2 = 1'b1;
    step("b_trim");
    bus.trim_2mhz_wr = 1'b0;
    steps("b_settle", 15);
    e_rdy2 = 1'b1; e_b2 = 1'b0;
    step("b_settled");

    // 16 MHz: stop from READY, trim while OFF, then drop/reassert during startup.
    bus.req_16mhz = 1'b0;
    e_en16 = 1'b0; e_rdy16 = 1'b0; e_b16 = 1'b1;
    step("c_stop");
    steps("c_stopping", 3);
    e_b16 = 1'b0;
    step("c_off");
    bus.trim_16mhz_wr = 1'b1; bus.trim_16mhz_in = 2'b10;
    e_tr16 = 2'b10;
    step("c_trim_off");
    bus.trim_16mhz_wr = 1'b0;
    bus.req_16mhz = 1'b1;
    e_en16 = 1'b1; e_b16 = 1'b1;
    step("c_start");
    steps("c_startup", 9);
    bus.req_16mhz = 1'b0;
    e_en16 = 1'b0;
    step("c_drop");
    bus.req_16mhz = 1'b1;
    steps("c_off_hold", 3);
    e_en16 = 1'b1;
    step("c_restart");
    steps("c_startup2", 63);
    e_rdy16 = 1'b1; e_b16 = 1'b0;
    step("c_ready");

    // 2 MHz: trim at startup edge 40 pushes rdy to 64 edges after the strobe.
    bus.req_2mhz = 1'b0;
    e_en2 = 1'b0; e_rdy2 = 1'b0; e_b2 = 1'b1;
    step("d_stop");
    steps("d_stopping", 3);
    e_b2 = 1'b0;
    step("d_off");
    bus.req_2mhz = 1'b1;
    e_en2 = 1'b1; e_b2 = 1'b1;
    step("d_start");
    steps("d_startup", 39);
    bus.trim_2mhz_wr = 1'b1; bus.trim_2mhz_in = 2'b01;
    e_tr2 = 2'b01;
    step("d_trim");
    bus.trim_2mhz_wr = 1'b0;
    steps("d_restarted", 63);
    e_rdy2 = 1'b1; e_b2 = 1'b0;
    step("d_ready");

    // Asynchronous reset with both channels READY.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    {e_en16, e_rdy16, e_b16, e_tr16} = '0;
    {e_en2,  e_rdy2,  e_b2,  e_tr2}  = '0;
    chk("rst_async");
    bus.req_16mhz = 1'b0;
    bus.req_2mhz  = 1'b0;
    #1;
    rst_n = 1'b1;
    step("rst_idle");

    // Both requests together, trim writes on both at edge 20.
    bus.req_16mhz = 1'b1; bus.req_2mhz = 1'b1;
    e_en16 = 1'b1; e_b16 = 1'b1; e_en2 = 1'b1; e_b2 = 1'b1;
    step("e_start");
    steps("e_startup", 19);
    bus.trim_16mhz_wr = 1'b1; bus.trim_16mhz_in = 2'b11;
    bus.trim_2mhz_wr  = 1'b1; bus.trim_2mhz_in  = 2'b10;
    e_tr16 = 2'b11; e_tr2 = 2'b10;
    step("e_trim");
    bus.trim_16mhz_wr = 1'b0; bus.trim_2mhz_wr = 1'b0;
    steps("e_restarted", 63);
    e_rdy16 = 1'b1; e_rdy2 = 1'b1; e_b16 = 1'b0; e_b2 = 1'b0;
    step("e_ready");

    // req low + trim together on 16 MHz (stop wins); 2 MHz settle restarted.
    bus.req_16mhz = 1'b0;
    bus.trim_16mhz_wr = 1'b1; bus.trim_16mhz_in = 2'b01;
    bus.trim_2mhz_wr  = 1'b1; bus.trim_2mhz_in  = 2'b11;
    e_en16 = 1'b0; e_rdy16 = 1'b0; e_tr16 = 2'b01; e_b16 = 1'b1;
    e_rdy2 = 1'b0; e_tr2 = 2'b11; e_b2 = 1'b1;
    step("f_stop_trim");
    bus.trim_16mhz_wr = 1'b0; bus.trim_2mhz_wr = 1'b0;
    steps("f_stopping", 3);
    e_b16 = 1'b0;
    step("f_off");
    bus.trim_2mhz_wr = 1'b1; bus.trim_2mhz_in = 2'b00;
    e_tr2 = 2'b00;
    step("f_resettle");
    bus.trim_2mhz_wr = 1'b0;
    steps("f_settle", 15);
    e_rdy2 = 1'b1; e_b2 = 1'b0;
    step("f_settled");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule : tb_rosc_ctrl

// File: doc/rosc_ctrl.md
ROSC_CTRL -- requirements
Module: rosc_ctrl

Interface
REQ-001 STARTUP_CYC, 64, clk cycles en_* must be high before rdy_* asserts (range 2..255).
REQ-002 SETTLE_CYC, 16, clk cycles rdy_* stays low after a trim change while running (range 2..255).
REQ-003 OFF_CYC, 4, minimum clk cycles en_* stays low after a disable (range 1..255).
REQ-004 clk  in  1  single always-on controller clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_16mhz / req_2mhz  in  1 each  level request to run the 16 MHz / 2 MHz oscillator.
REQ-007 trim_16mhz_wr / trim_2mhz_wr  in  1 each  single-cycle trim write strobe.
REQ-008 trim_16mhz_in / trim_2mhz_in  in  2 each  trim value captured on the strobe.
REQ-009 en_16mhz / en_2mhz  out  1 each  registered oscillator enables.
REQ-010 trim_16mhz / trim_2mhz  out  2 each  registered trim codes driven to the oscillator.
REQ-011 rdy_16mhz / rdy_2mhz  out  1 each  oscillator enabled and settled; downstream may use its clock.
REQ-012 busy  out  1  OR of both channels being in STARTUP, SETTLE or STOP.

Function
REQ-013 Each channel SHALL run an independent FSM: OFF, STARTUP, READY, SETTLE, STOP.
REQ-014 OFF: en=0, rdy=0; req sampled high -> STARTUP with en=1 on that same edge, counter loaded.
REQ-015 STARTUP: en=1, rdy=0; counter counts edges; after exactly STARTUP_CYC edges with en=1 -> READY, rdy=1.
REQ-016 READY: en=1, rdy=1; trim_wr -> SETTLE (rdy=0 on that edge, new trim driven on that edge); req low -> STOP.
REQ-017 SETTLE: en=1, rdy=0; after SETTLE_CYC edges -> READY; a further trim_wr in SETTLE reloads trim and restarts the count.
REQ-018 STOP: en=0, rdy=0; after OFF_CYC edges -> OFF; req ignored until OFF is reached.
REQ-019 req low in STARTUP or SETTLE -> STOP on that edge (en=0, rdy=0).
REQ-020 trim_wr in OFF or STOP updates trim immediately with no state change; trim_wr in STARTUP updates trim and restarts the STARTUP count.
REQ-021 Simultaneous req low and trim_wr: trim updates and STOP wins.
REQ-022 rdy SHALL never be high while en is low; en SHALL never change without a state transition.
REQ-023 Counters SHALL be 8 bits, down-counting, saturating at zero (no wrap).
REQ-024 Channels SHALL share no state; activity on one never alters timing of the other.

Reset
REQ-025 rst_n low SHALL asynchronously force both FSMs to OFF, counters 0, en_*=0, rdy_*=0, trim_*=2'b00, busy=0.
REQ-026 Reset asserted mid-STARTUP/READY/SETTLE SHALL drop en and rdy immediately, without an OFF_CYC wait.
REQ-027 After rst_n release, first request is honoured on the first clk edge sampling req high.

Structure
REQ-028 Shared package rosc_ctrl_pkg SHALL hold the state enum (OFF, STARTUP, READY, SETTLE, STOP), trim width 2 and counter width 8.
REQ-029 One sub-module rosc_chan (FSM + counter + trim register) SHALL be instantiated twice; top is wiring plus busy OR.

Verification
REQ-030 req_16mhz 0->1 at edge N -> en_16mhz=1 after edge N, rdy_16mhz=1 after edge N+64, busy high edges N..N+63.
REQ-031 In READY, trim_2mhz_wr with trim_2mhz_in=2'b11 -> trim_2mhz=2'b11 and rdy_2mhz=0 same edge, rdy_2mhz=1 16 edges later, en_2mhz stays 1.
REQ-032 req_16mhz dropped 10 edges into STARTUP then reasserted 1 edge later -> en=0 for exactly 4 edges, then a fresh 64-edge STARTUP.
REQ-033 trim_wr at STARTUP edge 40 -> rdy at 64 edges after the strobe, not at original edge 64.
REQ-034 rst_n pulsed low while both channels READY -> all outputs zero asynchronously before the next clk edge; trims return to 2'b00.
REQ-035 Both req rise together with trim writes on both channels at edge 20 -> channels' rdy timings independent and per REQ-033.
